// File: rtl/dmem_unit_pkg.sv
// dmem_unit_pkg: data-memory access encodings and shared types.
// The dm_type codes sit here next to the other control encodings so the
// decoder and the memory unit agree on a single definition.
package dmem_unit_pkg;

    // dm_type encodings (codes 101..111 are reserved and behave as word)
    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } acc_size_e;

    // Lane-placed store payload carried by one store-buffer entry
    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } sb_lane_t;

    // Access size from dm_type; anything unrecognised is a word access
    function automatic acc_size_e decode_size(input logic [2:0] dm_type);
        case (dm_type)
            DM_HALF, DM_HALF_U: decode_size = SZ_HALF;
            DM_BYTE, DM_BYTE_U: decode_size = SZ_BYTE;
            default:            decode_size = SZ_WORD;
        endcase
    endfunction

    // Loads that sign-extend their lane
    function automatic logic is_signed_load(input logic [2:0] dm_type);
        is_signed_load = (dm_type == DM_HALF) || (dm_type == DM_BYTE);
    endfunction

endpackage

// File: rtl/dmem_sbuf.sv
// dmem_sbuf: circular store buffer. Each entry holds a RAM word index and
// a lane-placed payload with byte enables. Pointers wrap modulo DEPTH
// (DEPTH is a power of two), count runs 0..DEPTH. match_vec flags every
// valid entry whose word index equals match_idx.
module dmem_sbuf
    import dmem_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq,
    input  logic [IDX_W-1:0] enq_idx,
    input  sb_lane_t         enq_lane,
    input  logic             deq,
    output logic [IDX_W-1:0] head_idx,
    output sb_lane_t         head_lane,
    output logic             full,
    output logic             empty,
    input  logic [IDX_W-1:0] match_idx,
    output logic [DEPTH-1:0] match_vec
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] idx_q  [DEPTH];
    sb_lane_t         lane_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_enq;
    logic             do_deq;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_enq   = enq && !full;
    assign do_deq   = deq && !empty;
    assign head_idx  = idx_q[rd_ptr];
    assign head_lane = lane_q[rd_ptr];

    // Pointer and occupancy bookkeeping; reset drops all pending entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + 1'b1;
            if (do_deq) rd_ptr <= rd_ptr + 1'b1;
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents only matter while covered by count
    always_ff @(posedge clk) begin
        if (do_enq) begin
            idx_q[wr_ptr]  <= enq_idx;
            lane_q[wr_ptr] <= enq_lane;
        end
    end

    // An entry is live when its distance from the read pointer is below count
    always_comb begin
        logic [PTR_W-1:0] offs;
        offs      = '0;
        match_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr;
            match_vec[i] = ({1'b0, offs} < count) && (idx_q[i] == match_idx);
        end
    end

endmodule

// File: rtl/dmem_unit.sv
// dmem_unit: CPU data memory with optional store buffer.
// Build option: define DMEM_STORE_BUFFER_EN to place a DEPTH-entry store
// buffer in front of the RAM; without it stores write the RAM directly and
// stall is tied low.
//
// Request handshake: mem_w / mem_r with addr, din, dm_type form the request.
// When stall is high the request was not taken; the CPU must hold it stable.
// A store is accepted on the rising edge of a cycle with stall low, and a
// load's dout is valid during a cycle with stall low.
module dmem_unit
    import dmem_unit_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_w,
    input  logic        mem_r,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [2:0]  dm_type,
    output logic [31:0] dout,
    output logic        stall,
    output logic        misalign
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   ram [MEM_WORDS];
    logic [AW-1:0] word_idx;
    acc_size_e     size;
    logic          misaligned_acc;
    logic          is_store;
    logic          is_load;
    sb_lane_t      st_lane;
    logic [31:0]   rd_word;
    logic [15:0]   half_sel;
    logic [7:0]    byte_sel;
    logic [31:0]   load_val;
    logic          dout_sel;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    sb_lane_t      wr_lane;
    logic          unused_addr;

    assign word_idx    = addr[AW+1:2];
    assign unused_addr = ^addr[31:AW+2];
    assign size        = decode_size(dm_type);

    // Misaligned: half on an odd byte or word off a word boundary
    assign misaligned_acc = (mem_w || mem_r) &&
                            (((size == SZ_HALF) && addr[0]) ||
                             ((size == SZ_WORD) && (addr[1:0] != 2'b00)));

    // Write wins when both requests are raised together
    assign is_store = mem_w && !misaligned_acc;
    assign is_load  = mem_r && !mem_w && !misaligned_acc;

    // Place right-aligned store data into its byte lanes
    always_comb begin
        st_lane = '0;
        case (size)
            SZ_BYTE: begin
                st_lane.data = {4{din[7:0]}};
                st_lane.be   = 4'b0001 << addr[1:0];
            end
            SZ_HALF: begin
                st_lane.data = {2{din[15:0]}};
                st_lane.be   = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_lane.data = din;
                st_lane.be   = 4'b1111;
            end
        endcase
    end

    // Select the addressed lane of the RAM word and extend it
    always_comb begin
        rd_word  = ram[word_idx];
        half_sel = addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (addr[1:0])
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        case (size)
            SZ_HALF: load_val = is_signed_load(dm_type) ?
                                {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
            SZ_BYTE: load_val = is_signed_load(dm_type) ?
                                {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
            default: load_val = rd_word;
        endcase
    end

`ifdef DMEM_STORE_BUFFER_EN
    logic [DEPTH-1:0] match_vec;
    logic             sb_full;
    logic             sb_empty;
    logic             hazard;
    logic             enq;
    logic             deq;
    logic [AW-1:0]    head_idx;
    sb_lane_t         head_lane;

    // A load must wait until every older store to its word has reached RAM
    assign hazard = is_load && (|match_vec);
    assign stall  = (is_store && sb_full) || hazard;
    assign enq    = is_store && !sb_full;
    // Drain when the RAM port is free, or to make room, or to clear a hazard
    assign deq    = !sb_empty && (!mem_r || sb_full || hazard);

    dmem_sbuf #(
        .DEPTH (DEPTH),
        .IDX_W (AW)
    ) u_sbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .enq       (enq),
        .enq_idx   (word_idx),
        .enq_lane  (st_lane),
        .deq       (deq),
        .head_idx  (head_idx),
        .head_lane (head_lane),
        .full      (sb_full),
        .empty     (sb_empty),
        .match_idx (word_idx),
        .match_vec (match_vec)
    );

    assign wr_en    = deq;
    assign wr_idx   = head_idx;
    assign wr_lane  = head_lane;
    assign dout_sel = is_load && !hazard;
`else
    assign stall    = 1'b0;
    assign wr_en    = is_store;
    assign wr_idx   = word_idx;
    assign wr_lane  = st_lane;
    assign dout_sel = is_load;
`endif

    assign dout = dout_sel ? load_val : 32'h0000_0000;

    // RAM byte-lane write; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_lane.be[b]) ram[wr_idx][8*b +: 8] <= wr_lane.data[8*b +: 8];
            end
        end
    end

    // Sticky misaligned-access flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              misalign <= 1'b0;
        else if (misaligned_acc) misalign <= 1'b1;
    end

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: directed checks for dmem_unit. Expectations that depend on
// the store buffer follow the DMEM_STORE_BUFFER_EN build option.
module tb_dmem_unit;
    import dmem_unit_pkg::*;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        mem_w   = 1'b0;
    logic        mem_r   = 1'b0;
    logic [31:0] addr    = '0;
    logic [31:0] din     = '0;
    logic [2:0]  dm_type = DM_WORD;
    logic [31:0] dout;
    logic        stall;
    logic        misalign;

    int n_vec = 0;
    int n_err = 0;

    // Clock
    always #5 clk = ~clk;

    dmem_unit #(
        .DEPTH     (4),
        .MEM_WORDS (1024)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_w    (mem_w),
        .mem_r    (mem_r),
        .addr     (addr),
        .din      (din),
        .dm_type  (dm_type),
        .dout     (dout),
        .stall    (stall),
        .misalign (misalign)
    );

    task automatic drive(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] t);
        mem_w   = w;
        mem_r   = r;
        addr    = a;
        din     = d;
        dm_type = t;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Unhazarded load: completes in the same cycle
    task automatic load_check(input string tag, input logic [31:0] a,
                              input logic [2:0] t, input logic [31:0] exp);
        drive(1'b0, 1'b1, a, 32'h0, t);
        check({tag, "_stall"}, {31'h0, stall}, 32'h0);
        check(tag, dout, exp);
        tick();
    endtask

    initial begin
        // Reset state
        idle();
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_dout", dout, 32'h0);
        check("rst_misalign", {31'h0, misalign}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Word store, one idle cycle, word load back
        drive(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, DM_WORD);
        check("st_word_stall", {31'h0, stall}, 32'h0);
        tick();
        idle();
        check("idle_dout", dout, 32'h0);
        tick();
        load_check("ld_word_10", 32'h10, DM_WORD, 32'hDEAD_BEEF);

        // Byte store then immediate signed byte load of the same address
        drive(1'b1, 1'b0, 32'h13, 32'h0000_0080, DM_BYTE);
        check("st_byte_stall", {31'h0, stall}, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h13, 32'h0, DM_BYTE);
`ifdef DMEM_STORE_BUFFER_EN
        check("ld_hazard_stall", {31'h0, stall}, 32'h1);
        tick();
`endif
        check("ld_byte_s_stall", {31'h0, stall}, 32'h0);
        check("ld_byte_s_13", dout, 32'hFFFF_FF80);
        tick();
        load_check("ld_byte_u_13", 32'h13, DM_BYTE_U, 32'h0000_0080);
        load_check("ld_word_merged", 32'h10, DM_WORD, 32'h80AD_BEEF);
        load_check("ld_half_s_12", 32'h12, DM_HALF, 32'hFFFF_80AD);
        load_check("ld_half_u_10", 32'h10, DM_HALF_U, 32'h0000_BEEF);
        load_check("ld_byte_s_11", 32'h11, DM_BYTE, 32'hFFFF_FFBE);
        load_check("ld_byte_u_10", 32'h10, DM_BYTE_U, 32'h0000_00EF);
        load_check("ld_reserved_10", 32'h10, 3'b111, 32'h80AD_BEEF);
        idle();
        check("idle_dout2", dout, 32'h0);
        tick();

        // Four stores with mem_r held high fill the buffer; fifth must wait
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'h20 + 32'(4 * k), 32'hA5A5_0020 + 32'(4 * k), DM_WORD);
            check("fill_stall", {31'h0, stall}, 32'h0);
            tick();
        end
        drive(1'b1, 1'b1, 32'h30, 32'hA5A5_0030, DM_WORD);
`ifdef DMEM_STORE_BUFFER_EN
        check("full_stall", {31'h0, stall}, 32'h1);
        tick();
`endif
        check("full_release", {31'h0, stall}, 32'h0);
        tick();

        // Load the newest buffered word: waits for four drains
        drive(1'b0, 1'b1, 32'h30, 32'h0, DM_WORD);
`ifdef DMEM_STORE_BUFFER_EN
        for (int i = 0; i < 4; i++) begin
            check("drain_stall", {31'h0, stall}, 32'h1);
            tick();
        end
`endif
        check("drain_done_stall", {31'h0, stall}, 32'h0);
        check("ld_word_30", dout, 32'hA5A5_0030);
        tick();
        load_check("ld_word_20", 32'h20, DM_WORD, 32'hA5A5_0020);
        load_check("ld_word_24", 32'h24, DM_WORD, 32'hA5A5_0024);
        load_check("ld_half_u_2e", 32'h2E, DM_HALF_U, 32'h0000_A5A5);

        // Misaligned accesses: flag, no data, RAM untouched, no stall
        drive(1'b1, 1'b0, 32'h04, 32'hCAFE_F00D, DM_WORD);
        tick();
        idle();
        check("pre_misalign", {31'h0, misalign}, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h05, 32'h0, DM_HALF);
        check("mis_ld_dout", dout, 32'h0);
        check("mis_ld_stall", {31'h0, stall}, 32'h0);
        tick();
        idle();
        check("misalign_set", {31'h0, misalign}, 32'h1);
        drive(1'b1, 1'b0, 32'h05, 32'h0000_1234, DM_HALF);
        check("mis_st_h_stall", {31'h0, stall}, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h06, 32'hFFFF_FFFF, DM_WORD);
        check("mis_st_w_stall", {31'h0, stall}, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h07, 32'h0000_5678, 3'b110);
        check("mis_st_rsv_stall", {31'h0, stall}, 32'h0);
        tick();
        idle();
        tick();
        load_check("ram_unchanged_04", 32'h04, DM_WORD, 32'hCAFE_F00D);
        idle();
        check("misalign_sticky", {31'h0, misalign}, 32'h1);
        tick();

        // Prior contents, then three buffered stores discarded by reset
        drive(1'b1, 1'b0, 32'h40, 32'h1111_2222, DM_WORD);
        tick();
        drive(1'b1, 1'b0, 32'h44, 32'h3333_4444, DM_WORD);
        tick();
        drive(1'b1, 1'b0, 32'h48, 32'h5555_6666, DM_WORD);
        tick();
        idle();
        tick();
        drive(1'b1, 1'b1, 32'h40, 32'hAAAA_0040, DM_WORD);
        tick();
        drive(1'b1, 1'b1, 32'h44, 32'hAAAA_0044, DM_WORD);
        tick();
        drive(1'b1, 1'b1, 32'h48, 32'hAAAA_0048, DM_WORD);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        check("rst2_misalign", {31'h0, misalign}, 32'h0);
        check("rst2_stall", {31'h0, stall}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
`ifdef DMEM_STORE_BUFFER_EN
        load_check("post_rst_40", 32'h40, DM_WORD, 32'h1111_2222);
        load_check("post_rst_44", 32'h44, DM_WORD, 32'h3333_4444);
        load_check("post_rst_48", 32'h48, DM_WORD, 32'h5555_6666);
`else
        load_check("post_rst_40", 32'h40, DM_WORD, 32'hAAAA_0040);
        load_check("post_rst_44", 32'h44, DM_WORD, 32'hAAAA_0044);
        load_check("post_rst_48", 32'h48, DM_WORD, 32'hAAAA_0048);
`endif
        idle();
        check("post_rst_misalign", {31'h0, misalign}, 32'h0);
        check("post_rst_dout", dout, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
